// File: rtl/starsoc_params.sv
// Shared SoC constants: standard 640x480@60 raster timing and sync polarity.
package starsoc_params;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping position counter plus decodes of the position it
// will hold after the next edge, so the parent can register them in step with it.
module timing_axis #(
  parameter int   VISIBLE     = starsoc_params::H_VISIBLE,
  parameter int   FRONT       = starsoc_params::H_FRONT,
  parameter int   SYNC        = starsoc_params::H_SYNC,
  parameter int   BACK        = starsoc_params::H_BACK,
  parameter logic SYNC_ACTIVE = starsoc_params::SYNC_ACTIVE
) (
  input  logic                   p_clock,
  input  logic                   reset,
  input  logic                   advance,
  output starsoc_params::coord_t count,
  output logic                   active,
  output logic                   sync,
  output logic                   wrap
);

  localparam int TOTAL      = VISIBLE + FRONT + SYNC + BACK;
  localparam int SYNC_START = VISIBLE + FRONT;
  localparam int SYNC_END   = VISIBLE + FRONT + SYNC;
  localparam starsoc_params::coord_t LAST = starsoc_params::coord_t'(TOTAL - 1);

  if (TOTAL > 1024) begin : g_total_too_large
    $error("timing_axis: total %0d exceeds 1024", TOTAL);
  end

  starsoc_params::coord_t next_count;

  assign wrap = advance && (count == LAST);

  // Next position and the decodes that will accompany it.
  always_comb begin
    next_count = count;
    if (!advance) begin
      next_count = count;
    end else if (count == LAST) begin
      next_count = {starsoc_params::COORD_W{1'b0}};
    end else begin
      next_count = count + starsoc_params::coord_t'(1);
    end
    active = (int'(next_count) < VISIBLE);
    if ((int'(next_count) >= SYNC_START) && (int'(next_count) < SYNC_END)) begin
      sync = SYNC_ACTIVE;
    end else begin
      sync = ~SYNC_ACTIVE;
    end
  end

  // Reset parks on the last position so the first edge lands on 0.
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      count <= LAST;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing: pixel position, syncs, visible flag, line/frame/vblank
// strobes and a frame counter, all registered so they describe the same pixel.
module video_timing_gen #(
  parameter int   H_VISIBLE   = starsoc_params::H_VISIBLE,
  parameter int   H_FRONT     = starsoc_params::H_FRONT,
  parameter int   H_SYNC      = starsoc_params::H_SYNC,
  parameter int   H_BACK      = starsoc_params::H_BACK,
  parameter int   V_VISIBLE   = starsoc_params::V_VISIBLE,
  parameter int   V_FRONT     = starsoc_params::V_FRONT,
  parameter int   V_SYNC      = starsoc_params::V_SYNC,
  parameter int   V_BACK      = starsoc_params::V_BACK,
  parameter logic SYNC_ACTIVE = starsoc_params::SYNC_ACTIVE
) (
  input  logic        p_clock,
  input  logic        reset,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        vblank_start,
  output logic [15:0] frame_count
);

  logic h_active, h_sync, h_wrap;
  logic v_active, v_sync, v_wrap;
  logic vblank_next;
  logic [15:0] frame_count_next;

  timing_axis #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_h_axis (
    .p_clock(p_clock), .reset(reset), .advance(1'b1),
    .count(x), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  timing_axis #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_v_axis (
    .p_clock(p_clock), .reset(reset), .advance(h_wrap),
    .count(y), .active(v_active), .sync(v_sync), .wrap(v_wrap)
  );

  // Strobe and counter decodes from the current counters; a frame starts exactly when both axes wrap.
  always_comb begin
    vblank_next = h_wrap && !v_wrap && (int'(y) == V_VISIBLE - 1);
    if (v_wrap) begin
      frame_count_next = frame_count + 16'd1;
    end else begin
      frame_count_next = frame_count;
    end
  end

  // Register every decoded output alongside the x/y counters.
  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      hsync        <= ~SYNC_ACTIVE;
      vsync        <= ~SYNC_ACTIVE;
      video_on     <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= 16'd0;
    end else begin
      hsync        <= h_sync;
      vsync        <= v_sync;
      video_on     <= h_active && v_active;
      line_start   <= h_wrap;
      frame_start  <= v_wrap;
      vblank_start <= vblank_next;
      frame_count  <= frame_count_next;
    end
  end

endmodule
